// File: rtl/sspim_seq.sv
// sspim_seq: drives the SPI master register bus for every transmit word
// (write data, write control with request, poll, read back) and queues results.
module sspim_seq #(
   parameter int         RX_DEPTH   = 4,
   parameter logic [7:0] CTRL_ADDR  = 8'h00,
   parameter logic [7:0] WDATA_ADDR = 8'h04,
   parameter logic [7:0] RDATA_ADDR = 8'h08,
   parameter int         REQ_BIT    = 31,
   parameter int         POLL_GAP   = 4,
   parameter int         POLL_MAX   = 1023
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [31:0] cfg_ctrl_word,
   input  logic        tx_valid,
   input  logic [31:0] tx_data,
   output logic        tx_ready,
   output logic        rx_valid,
   output logic [31:0] rx_data,
   input  logic        rx_ready,
   output logic        reg_cs,
   output logic        reg_wr,
   output logic [7:0]  reg_addr,
   output logic [31:0] reg_wdata,
   output logic [3:0]  reg_be,
   input  logic [31:0] reg_rdata,
   input  logic        reg_ack,
   output logic        busy,
   output logic [15:0] xfer_cnt,
   output logic        timeout_err,
   output logic [2:0]  dbg_state
);

   localparam int PW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
   localparam int CW = $clog2(RX_DEPTH) + 1;
   localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [31:0]   REQ_MASK  = 32'd1 << REQ_BIT;
   localparam logic [9:0]    POLL_LAST = 10'(POLL_MAX - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_DATA = 3'd1,
      S_WR_CTRL = 3'd2,
      S_GAP     = 3'd3,
      S_POLL    = 3'd4,
      S_RD_DATA = 3'd5
   } state_t;

   state_t        state;
   logic [31:0]   tx_word;
   logic [GW-1:0] gap_cnt;
   logic [9:0]    poll_cnt;

   logic [31:0]   mem [RX_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          fifo_free;
   logic          push;
   logic          pop;

   // Only one word is ever in flight, so a free slot at accept time is the
   // reserved slot for that word and the FIFO can never overflow.
   assign fifo_free = (count != CW'(RX_DEPTH));
   assign push      = (state == S_RD_DATA) && reg_cs && reg_ack;
   assign pop       = rx_valid && rx_ready;
   assign rx_valid  = (count != '0);
   assign rx_data   = mem[rd_ptr];
   assign busy      = (state != S_IDLE);
   assign dbg_state = state;

   // Handshakes: rx is plain valid/ready (transfer when both are 1 at a clock
   // edge). tx_ready is a registered one-cycle pulse raised in the cycle after
   // tx_data was latched; the source must hold tx_valid/tx_data until it sees
   // tx_valid & tx_ready at a clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         tx_ready    <= 1'b0;
         tx_word     <= '0;
         gap_cnt     <= '0;
         poll_cnt    <= '0;
         reg_cs      <= 1'b0;
         reg_wr      <= 1'b0;
         reg_addr    <= '0;
         reg_wdata   <= '0;
         reg_be      <= '0;
         xfer_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         tx_ready <= 1'b0;
         case (state)
            S_IDLE: begin
               if (enable && tx_valid && fifo_free && !timeout_err) begin
                  tx_ready <= 1'b1;
                  tx_word  <= tx_data;
                  state    <= S_WR_DATA;
               end
            end
            // Each access state launches on its first cycle (reg_cs low) and
            // leaves on ack, so reg_cs is low for at least one cycle between accesses.
            S_WR_DATA: begin
               if (!reg_cs) begin
                  reg_cs    <= 1'b1;
                  reg_wr    <= 1'b1;
                  reg_be    <= 4'hF;
                  reg_addr  <= WDATA_ADDR;
                  reg_wdata <= tx_word;
               end else if (reg_ack) begin
                  reg_cs <= 1'b0;
                  state  <= S_WR_CTRL;
               end
            end
            S_WR_CTRL: begin
               if (!reg_cs) begin
                  reg_cs    <= 1'b1;
                  reg_wr    <= 1'b1;
                  reg_be    <= 4'hF;
                  reg_addr  <= CTRL_ADDR;
                  reg_wdata <= cfg_ctrl_word | REQ_MASK;
                  poll_cnt  <= '0;
               end else if (reg_ack) begin
                  reg_cs  <= 1'b0;
                  gap_cnt <= '0;
                  state   <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) state <= S_POLL;
               else gap_cnt <= gap_cnt + GW'(1);
            end
            S_POLL: begin
               if (!reg_cs) begin
                  reg_cs   <= 1'b1;
                  reg_wr   <= 1'b0;
                  reg_be   <= 4'hF;
                  reg_addr <= CTRL_ADDR;
               end else if (reg_ack) begin
                  reg_cs <= 1'b0;
                  if (!reg_rdata[REQ_BIT]) begin
                     state <= S_RD_DATA;
                  end else if (poll_cnt == POLL_LAST) begin
                     timeout_err <= 1'b1;
                     state       <= S_IDLE;
                  end else begin
                     poll_cnt <= poll_cnt + 10'd1;
                     gap_cnt  <= '0;
                     state    <= S_GAP;
                  end
               end
            end
            S_RD_DATA: begin
               if (!reg_cs) begin
                  reg_cs   <= 1'b1;
                  reg_wr   <= 1'b0;
                  reg_be   <= 4'hF;
                  reg_addr <= RDATA_ADDR;
               end else if (reg_ack) begin
                  reg_cs   <= 1'b0;
                  xfer_cnt <= xfer_cnt + 16'd1;
                  state    <= S_IDLE;
               end
            end
            default: begin
               reg_cs <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
         if (!enable) timeout_err <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < RX_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= reg_rdata;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_sspim_seq.sv
// Scoreboard bench for sspim_seq: a register-bus slave model checks every access
// against an expected queue, and an RX monitor checks popped words in order.
module tb_sspim_seq;

   localparam logic [7:0] CTRL_A  = 8'h00;
   localparam logic [7:0] WDATA_A = 8'h04;
   localparam logic [7:0] RDATA_A = 8'h08;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] cfg_ctrl_word = '0;
   logic        tx_valid = 1'b0;
   logic [31:0] tx_data = '0;
   logic        tx_ready;
   logic        rx_valid;
   logic [31:0] rx_data;
   logic        rx_ready = 1'b0;
   logic        reg_cs;
   logic        reg_wr;
   logic [7:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [3:0]  reg_be;
   logic [31:0] reg_rdata = '0;
   logic        reg_ack = 1'b0;
   logic        busy;
   logic [15:0] xfer_cnt;
   logic        timeout_err;
   logic [2:0]  dbg_state;

   always #5 clk = ~clk;

   sspim_seq dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_ctrl_word(cfg_ctrl_word),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_be(reg_be), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
      .busy(busy), .xfer_cnt(xfer_cnt), .timeout_err(timeout_err), .dbg_state(dbg_state)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic [44:0] bus_exp_q[$];
   logic [31:0] rx_exp_q[$];
   logic [31:0] drv_q[$];
   logic [31:0] slave_rd_q[$];
   bit          bus_chk = 1'b0;
   int          ack_dly = 0;
   int          clear_at = 1;
   int          poll_n = 0;
   int          wait_cnt = 0;
   logic [31:0] ctrl_val = '0;
   logic [44:0] snap = '0;
   bit          stable = 1'b1;
   bit          tx_hs = 1'b0;
   int          acc_cnt = 0;

   function automatic logic [44:0] acc(input bit wr, input logic [7:0] a, input logic [31:0] d);
      return {wr, 4'hF, a, (wr ? d : 32'h0)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_xfer(input logic [15:0] tgt, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (xfer_cnt == tgt && !busy) break;
      end
      chk("xfer_cnt", xfer_cnt, tgt);
      chk("busy_after_xfer", busy, 0);
      cyc(1);
   endtask

   task automatic wait_state(input logic [2:0] st, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (dbg_state == st) begin
            seen = 1'b1;
            break;
         end
      end
      chk("reach_state", seen, 1);
   endtask

   // Register-bus slave: acks after ack_dly wait cycles and scores each access.
   initial begin
      logic [44:0] cur;
      forever begin
         @(negedge clk);
         cur = {reg_wr, reg_be, reg_addr, (reg_wr ? reg_wdata : 32'h0)};
         if (reg_ack) begin
            reg_ack = 1'b0;
         end else if (reg_cs) begin
            if (wait_cnt == 0) begin
               snap   = cur;
               stable = 1'b1;
            end else if (cur != snap) begin
               stable = 1'b0;
            end
            if (wait_cnt >= ack_dly) begin
               wait_cnt = 0;
               if (bus_chk) begin
                  if (bus_exp_q.size() == 0) begin
                     n_cmp++;
                     n_err++;
                     $display("FAIL bus_unexpected: got %0h, expected no access", cur);
                  end else begin
                     chk("bus_access", cur, bus_exp_q.pop_front());
                  end
               end
               if (ack_dly > 0) chk("bus_stable", stable, 1);
               if (reg_wr) begin
                  if (reg_addr == CTRL_A) begin
                     ctrl_val = reg_wdata;
                     poll_n   = 0;
                  end
               end else if (reg_addr == CTRL_A) begin
                  poll_n++;
                  reg_rdata = (clear_at != 0 && poll_n >= clear_at) ?
                              (ctrl_val & 32'h7FFF_FFFF) : (ctrl_val | 32'h8000_0000);
               end else if (reg_addr == RDATA_A) begin
                  reg_rdata = (slave_rd_q.size() != 0) ? slave_rd_q.pop_front() : 32'hBAD0_0000;
               end
               reg_ack = 1'b1;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // RX monitor and tx handshake observer.
   initial begin
      forever begin
         @(negedge clk);
         if (rx_valid && rx_ready) begin
            if (rx_exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL rx_unexpected: got %0h, expected no word", rx_data);
            end else begin
               chk("rx_data", rx_data, rx_exp_q.pop_front());
            end
         end
         if (tx_valid && tx_ready) begin
            tx_hs = 1'b1;
            acc_cnt++;
         end
      end
   end

   // Transmit driver: presents the head of drv_q until it is accepted.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (tx_hs) begin
            if (drv_q.size() != 0) void'(drv_q.pop_front());
            tx_hs = 1'b0;
         end
         if (drv_q.size() != 0) begin
            tx_valid = 1'b1;
            tx_data  = drv_q[0];
         end else begin
            tx_valid = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc0;
      // Reset values
      cyc(3);
      chk("rst_reg_cs", reg_cs, 0);
      chk("rst_reg_wr", reg_wr, 0);
      chk("rst_reg_addr", reg_addr, 0);
      chk("rst_reg_wdata", reg_wdata, 0);
      chk("rst_reg_be", reg_be, 0);
      chk("rst_tx_ready", tx_ready, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_xfer_cnt", xfer_cnt, 0);
      chk("rst_timeout", timeout_err, 0);
      reset_n = 1'b1;
      cyc(2);
      enable = 1'b1;

      // Single transfer, request clears on 2nd poll
      cfg_ctrl_word = 32'h0001_0203;
      clear_at = 2;
      bus_chk  = 1'b1;
      bus_exp_q.push_back(acc(1, WDATA_A, 32'hA5A5_1234));
      bus_exp_q.push_back(acc(1, CTRL_A, 32'h8001_0203));
      bus_exp_q.push_back(acc(0, CTRL_A, 0));
      bus_exp_q.push_back(acc(0, CTRL_A, 0));
      bus_exp_q.push_back(acc(0, RDATA_A, 0));
      slave_rd_q.push_back(32'h0000_00C3);
      rx_exp_q.push_back(32'h0000_00C3);
      drv_q.push_back(32'hA5A5_1234);
      wait_xfer(16'd1, 200);
      chk("single_bus_left", bus_exp_q.size(), 0);
      chk("single_rx_valid", rx_valid, 1);
      rx_ready = 1'b1;
      cyc(3);
      chk("single_rx_left", rx_exp_q.size(), 0);
      chk("single_rx_empty", rx_valid, 0);
      bus_chk = 1'b0;

      // Back-to-back with backpressure
      rx_ready = 1'b0;
      clear_at = 1;
      acc0 = acc_cnt;
      for (int i = 0; i < 6; i++) begin
         slave_rd_q.push_back(32'hC000_0000 + i);
         rx_exp_q.push_back(32'hC000_0000 + i);
         drv_q.push_back(32'hB000_0000 + i);
      end
      wait_xfer(16'd5, 400);
      cyc(60);
      chk("bp_xfer_cnt", xfer_cnt, 5);
      chk("bp_accepted", acc_cnt - acc0, 4);
      chk("bp_pending", drv_q.size(), 2);
      chk("bp_rx_valid", rx_valid, 1);
      chk("bp_tx_ready", tx_ready, 0);
      rx_ready = 1'b1;
      wait_xfer(16'd7, 400);
      cyc(4);
      chk("bp_rx_left", rx_exp_q.size(), 0);
      chk("bp_accepted_all", acc_cnt - acc0, 6);

      // Poll timeout
      clear_at = 0;
      drv_q.push_back(32'h3333_0001);
      for (int i = 0; i < 8000; i++) begin
         @(negedge clk);
         if (timeout_err) break;
      end
      chk("to_flag", timeout_err, 1);
      chk("to_polls", poll_n, 1023);
      chk("to_xfer_cnt", xfer_cnt, 7);
      chk("to_busy", busy, 0);
      chk("to_rx_valid", rx_valid, 0);
      cyc(1);
      acc0 = acc_cnt;
      slave_rd_q.push_back(32'h0000_00E7);
      rx_exp_q.push_back(32'h0000_00E7);
      drv_q.push_back(32'h3333_0002);
      cyc(40);
      chk("to_blocked", acc_cnt - acc0, 0);
      chk("to_flag_held", timeout_err, 1);
      clear_at = 1;
      enable = 1'b0;
      cyc(1);
      chk("to_cleared", timeout_err, 0);
      enable = 1'b1;
      wait_xfer(16'd8, 200);
      cyc(3);
      chk("to_resume_rx", rx_exp_q.size(), 0);

      // Slow bus: identical results with 5 wait cycles per access
      ack_dly = 5;
      clear_at = 2;
      bus_chk = 1'b1;
      bus_exp_q.push_back(acc(1, WDATA_A, 32'hA5A5_1234));
      bus_exp_q.push_back(acc(1, CTRL_A, 32'h8001_0203));
      bus_exp_q.push_back(acc(0, CTRL_A, 0));
      bus_exp_q.push_back(acc(0, CTRL_A, 0));
      bus_exp_q.push_back(acc(0, RDATA_A, 0));
      slave_rd_q.push_back(32'h0000_00C3);
      rx_exp_q.push_back(32'h0000_00C3);
      drv_q.push_back(32'hA5A5_1234);
      wait_xfer(16'd9, 400);
      cyc(3);
      chk("slow_bus_left", bus_exp_q.size(), 0);
      chk("slow_rx_left", rx_exp_q.size(), 0);
      bus_chk = 1'b0;
      ack_dly = 0;

      // Disable during GAP
      clear_at = 1;
      slave_rd_q.push_back(32'h0000_0055);
      rx_exp_q.push_back(32'h0000_0055);
      drv_q.push_back(32'h4444_0001);
      wait_state(3'd3, 100);
      cyc(1);
      enable = 1'b0;
      wait_xfer(16'd10, 200);
      cyc(3);
      chk("dis_rx_left", rx_exp_q.size(), 0);
      acc0 = acc_cnt;
      drv_q.push_back(32'h4444_0002);
      cyc(30);
      chk("dis_ignored", acc_cnt - acc0, 0);
      chk("dis_busy", busy, 0);
      drv_q.delete();
      cyc(3);
      enable = 1'b1;

      // Async reset during POLL with 2 words queued
      rx_ready = 1'b0;
      slave_rd_q.push_back(32'h0000_0011);
      slave_rd_q.push_back(32'h0000_0022);
      drv_q.push_back(32'h5555_0001);
      drv_q.push_back(32'h5555_0002);
      wait_xfer(16'd12, 200);
      chk("ar_rx_valid_pre", rx_valid, 1);
      clear_at = 0;
      drv_q.push_back(32'h5555_0003);
      wait_state(3'd4, 100);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar_reg_cs", reg_cs, 0);
      chk("ar_rx_valid", rx_valid, 0);
      chk("ar_xfer_cnt", xfer_cnt, 0);
      chk("ar_busy", busy, 0);
      drv_q.delete();
      slave_rd_q.delete();
      cyc(2);
      reset_n = 1'b1;
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sspim_seq.md
Name: sspim_seq

Overview:
- Autonomous transfer sequencer that sits directly upstream of the SPI master, on its register bus.
- Takes 32-bit transmit words from a ready/valid stream and runs the full register transaction for each word: write data, write control with op request set, poll until the request clears, read received data.
- Pushes each received word into an internal RX FIFO, so the CPU or a DMA can stream bytes without polling the SPI master.

Parameters:
- RX_DEPTH, 4, RX FIFO depth in words (power of 2, ≥2).
- CTRL_ADDR, 8'h00, SPI master control register address.
- WDATA_ADDR, 8'h04, SPI master transmit data register address.
- RDATA_ADDR, 8'h08, SPI master receive data register address.
- REQ_BIT, 31, bit position of op request in the control register.
- POLL_GAP, 4, idle cycles between status polls (≥1).
- POLL_MAX, 1023, polls before timeout (10-bit counter).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  sequencer enable
- cfg_ctrl_word  in  32  control word (target, type, size, sck, cs); REQ_BIT is forced to 1 by the block
- tx_valid  in  1  transmit word valid
- tx_data  in  32  transmit word
- tx_ready  out  1  transmit word accepted
- rx_valid  out  1  RX FIFO not empty
- rx_data  out  32  RX FIFO head word
- rx_ready  in  1  RX pop
- reg_cs  out  1  register bus chip select
- reg_wr  out  1  register bus write
- reg_addr  out  8  register bus address
- reg_wdata  out  32  register bus write data
- reg_be  out  4  register bus byte enables
- reg_rdata  in  32  register bus read data
- reg_ack  in  1  register bus acknowledge
- busy  out  1  state machine not in IDLE
- xfer_cnt  out  16  completed transfers, wraps at 16'hFFFF→0
- timeout_err  out  1  sticky poll timeout flag; cleared when enable is low

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on reset_n.
- Reset values: all outputs 0, including reg_cs, tx_ready, rx_valid, busy, xfer_cnt and timeout_err. State is IDLE, RX FIFO empty.
- Register bus: reg_cs, reg_wr, reg_addr, reg_wdata and reg_be are registered and held stable until the cycle reg_ack=1. reg_cs drops the cycle after ack. reg_be is always 4'hF. No back-to-back access; at least 1 idle cycle separates accesses.
- IDLE → WR_DATA when all of: enable=1, tx_valid=1, RX FIFO has ≥1 free slot (counting the slot reserved for this word), timeout_err=0.
  - tx_ready pulses 1 for exactly that cycle.
  - tx_data is latched.
- WR_DATA: write latched word to WDATA_ADDR. On ack → WR_CTRL.
- WR_CTRL: write cfg_ctrl_word | (1<<REQ_BIT) to CTRL_ADDR. cfg_ctrl_word is sampled at state entry. On ack → GAP.
- GAP: wait POLL_GAP cycles → POLL.
- POLL: read CTRL_ADDR. On ack:
  - reg_rdata[REQ_BIT]=0 → RD_DATA.
  - Otherwise increment poll_cnt. If poll_cnt reaches POLL_MAX, set timeout_err and go to IDLE with no RX push. Else → GAP.
- RD_DATA: read RDATA_ADDR. On ack, push reg_rdata to the RX FIFO, increment xfer_cnt → IDLE.
- Throughput: minimum IDLE-to-IDLE time with 1-cycle acks and immediate completion is 4 accesses + gaps. Latency from tx accept to rx_valid must be ≤ 12 + POLL_GAP cycles with 1-cycle ack.
- RX FIFO: first-word fall-through. rx_data is valid while rx_valid=1; pop on rx_valid&rx_ready.
  - Simultaneous push and pop when full is legal, because the reserved-slot rule guarantees no overflow.
  - Pop when empty is ignored.
- enable deasserted mid-transfer: the current word runs to completion (including its RX push); then the block stays in IDLE. timeout_err clears while enable=0.
- Reset mid-operation: bus released immediately (reg_cs=0), FIFO flushed, counters cleared.
- Pending access: the bus stays asserted indefinitely while reg_ack=0. There is no bus-level timeout.

Test Plan:
- Single transfer:
  - Stimulus: cfg_ctrl_word=32'h0001_0203, tx_data=32'hA5A5_1234; slave clears the req bit on the 2nd poll; RDATA returns 32'h0000_00C3.
  - Required: bus sequence is W 0x04=A5A51234, W 0x00=8001_0203, R 0x00 ×2, R 0x08. Then rx_data=C3, xfer_cnt=1.
- Back-to-back with backpressure:
  - Stimulus: 6 words pushed, rx_ready=0, RX_DEPTH=4.
  - Required: exactly 4 transfers. tx_ready stays 0 for the 5th word until a pop. After popping all, the 6 words return in order.
- Timeout:
  - Stimulus: the req bit is never cleared.
  - Required: after 1023 polls, timeout_err=1, no RX push, tx_ready stays 0.
  - Then pulse enable low: timeout_err=0 and transfers resume.
- Slow bus:
  - Stimulus: reg_ack delayed 5 cycles on every access.
  - Required: reg_addr, reg_wdata and reg_wr stay stable during the wait; results are identical to the single-transfer case.
- Disable mid-transfer:
  - Stimulus: enable drops during GAP.
  - Required: the transfer completes, the word is pushed, the block returns to IDLE with busy=0 and ignores further tx_valid.
- Async reset:
  - Stimulus: reset_n asserted during POLL with 2 words in the FIFO.
  - Required: reg_cs=0 immediately, rx_valid=0, xfer_cnt=0.
